// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite slave SRAM with pipelined address/data phases,
//               byte/halfword writes, programmable wait states and
//               read-after-write forwarding.
//               Optional macro AHB_SRAM_ERR_EN enables two-cycle ERROR
//               responses for out-of-range, oversized or misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);

    localparam int         AW        = $clog2(MEM_WORDS) + 2;
    localparam int         WW        = AW - 2;
    localparam bit         USE_WAIT  = (WAIT_STATES > 0);
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      wait_cnt;
    logic [31:0]     mem [MEM_WORDS];

    // Data-phase bookkeeping for the transfer accepted on the previous edge
    logic            dp_valid;
    logic            dp_write;
    logic [WW-1:0]   dp_word;
    logic [3:0]      dp_lanes;
    logic [31:0]     rdata_q;

    logic            accept;
    logic            acc_err;
    logic            acc_ok;
    logic [3:0]      acc_lanes;
    logic [WW-1:0]   acc_word;
    logic [31:0]     mem_rdata;
    logic [31:0]     fwd_rdata;
    logic            commit;

    // Burst/protection/lock qualifiers carry no meaning for a plain SRAM
    logic            unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:AW]};

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign acc_word = HADDR[AW-1:2];

`ifdef AHB_SRAM_ERR_EN
    assign acc_err = (HADDR[31:AW] != '0) | (HSIZE > 3'd2)
                   | ((HSIZE == 3'd1) & HADDR[0])
                   | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
`else
    assign acc_err = 1'b0;
`endif
    assign acc_ok = accept & ~acc_err;

    // Little-endian lane decode; misaligned accesses fall onto their aligned lanes
    always_comb begin
        case (HSIZE)
            3'd0:    acc_lanes = 4'b0001 << HADDR[1:0];
            3'd1:    acc_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            default: acc_lanes = 4'b1111;
        endcase
    end

    assign HREADYOUT = (state != ST_WAIT) && (state != ST_ERR1);
    assign commit    = dp_valid & dp_write & HREADYOUT;
    assign mem_rdata = mem[acc_word];

    // Forward lanes of a write committing on this edge into a same-word read
    always_comb begin
        fwd_rdata = mem_rdata;
        for (int b = 0; b < 4; b++) begin
            if (commit && (dp_word == acc_word) && dp_lanes[b]) begin
                fwd_rdata[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE, DATA and ERR2 are the cycles in which a new transfer can be accepted
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                if (accept && acc_err) begin
                    state_nxt = ST_ERR1;
                end else if (acc_ok && USE_WAIT) begin
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Wait-state down-counter, reloaded on each accepted non-error transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt <= 3'd0;
        end else if (acc_ok && USE_WAIT) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ST_WAIT) && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Capture address-phase controls and read data when the bus advances
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_word  <= '0;
            dp_lanes <= 4'b0000;
            rdata_q  <= 32'd0;
        end else if (HREADY) begin
            dp_valid <= acc_ok;
            if (accept) begin
                dp_write <= HWRITE;
                dp_word  <= acc_word;
                dp_lanes <= acc_lanes;
                rdata_q  <= (acc_ok && !HWRITE) ? fwd_rdata : 32'd0;
            end
        end
    end

    // SRAM array write on the edge that completes a write data phase
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (dp_lanes[b]) begin
                    mem[dp_word][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HRDATA = rdata_q;

`ifdef AHB_SRAM_ERR_EN
    assign HRESP = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
`else
    assign HRESP = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_sram_slave
// Description : Self-checking bench for ahb_sram_slave. Two instances
//               (zero and three wait states) share one stimulus bus; a
//               byte-addressed reference memory predicts every response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

    localparam int MEM_WORDS = 1024;
    localparam int BYTES     = MEM_WORDS * 4;

    logic        clk;
    logic        rst_n;
    logic        hsel;
    logic        use3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] pend_wd;

    logic        sel0, sel3;
    logic [31:0] rdata0, rdata3;
    logic        ro0, ro3;
    logic [1:0]  resp0, resp3;
    logic [31:0] rdata;
    logic        ro;
    logic [1:0]  resp;
    int          ws_cur;

    assign sel0   = hsel & ~use3;
    assign sel3   = hsel & use3;
    assign rdata  = use3 ? rdata3 : rdata0;
    assign ro     = use3 ? ro3 : ro0;
    assign resp   = use3 ? resp3 : resp0;
    assign ws_cur = use3 ? 3 : 0;

    ahb_sram_slave #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001), .HPROT(4'b0011),
        .HMASTLOCK(1'b0), .HREADY(ro0), .HWDATA(hwdata), .HRDATA(rdata0),
        .HREADYOUT(ro0), .HRESP(resp0)
    );

    ahb_sram_slave #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001), .HPROT(4'b0011),
        .HMASTLOCK(1'b0), .HREADY(ro3), .HWDATA(hwdata), .HRDATA(rdata3),
        .HREADYOUT(ro3), .HRESP(resp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mb [BYTES];
    bit          dp_active;
    bit          dp_write;
    bit          dp_err;
    logic [31:0] dp_addr;
    logic [2:0]  dp_size;
    logic [31:0] dp_exp;
    int          dp_wait;
    int          dp_cycles;
    logic [31:0] last_rd;

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        base = int'(a % 32'(BYTES)) & ~3;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    function automatic bit model_err(input logic [31:0] a, input logic [2:0] sz);
`ifdef AHB_SRAM_ERR_EN
        return (a >= 32'(BYTES)) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
               (sz == 3'd2 && a[1:0] != 2'b00);
`else
        return (a != a) && (sz != sz);
`endif
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int n;
        int base;
        int ba;
        n    = 1 << ((sz > 3'd2) ? 2 : int'(sz));
        base = int'(a % 32'(BYTES)) & ~(n - 1);
        for (int i = 0; i < n; i++) begin
            ba     = (base + i) % BYTES;
            mb[ba] = wd[8*(ba % 4) +: 8];
        end
    endtask

    // Compare process: one sample per cycle, well away from the rising edge
    initial begin
        dp_active = 0; dp_write = 0; dp_err = 0; dp_addr = 0; dp_size = 0;
        dp_exp = 0; dp_wait = 0; dp_cycles = 0; last_rd = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                dp_active = 0;
                check("rst_hready", {31'd0, ro}, 32'd1);
                check("rst_hresp", {30'd0, resp}, 32'd0);
                check("rst_hrdata", rdata, 32'd0);
                continue;
            end
            if (dp_active) dp_cycles++;
            if (!dp_active) begin
                check("idle_hready", {31'd0, ro}, 32'd1);
                check("idle_hresp", {30'd0, resp}, 32'd0);
            end else if (dp_err) begin
                if (dp_wait == 0) begin
                    check("err1_hready", {31'd0, ro}, 32'd0);
                    check("err1_hresp", {30'd0, resp}, 32'd1);
                    dp_wait = 1;
                end else begin
                    check("err2_hready", {31'd0, ro}, 32'd1);
                    check("err2_hresp", {30'd0, resp}, 32'd1);
                    check("err_hrdata", rdata, 32'd0);
                end
            end else begin
                check("dp_hresp", {30'd0, resp}, 32'd0);
                if (!ro) begin
                    dp_wait++;
                    check("wait_not_too_long", {31'd0, (dp_wait <= ws_cur)}, 32'd1);
                end else begin
                    check("wait_len", 32'(dp_wait), 32'(ws_cur));
                    if (dp_write) begin
                        model_write(dp_addr, dp_size, hwdata);
                    end else begin
                        check("read_data", rdata, dp_exp);
                        last_rd = rdata;
                    end
                end
            end
            if (ro) begin
                if (hsel && htrans[1]) begin
                    dp_active = 1;
                    dp_write  = hwrite;
                    dp_addr   = haddr;
                    dp_size   = hsize;
                    dp_err    = model_err(haddr, hsize);
                    dp_wait   = 0;
                    dp_exp    = dp_err ? 32'd0 : model_word(haddr);
                end else begin
                    dp_active = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Drive one address phase (HWDATA of the previous beat alongside), wait for acceptance
    task automatic issue(input bit v, input bit w, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [1:0] tr);
        int n;
        n      = 0;
        hsel   = v;
        htrans = v ? tr : 2'b00;
        hwrite = w;
        hsize  = sz;
        haddr  = a;
        hwdata = pend_wd;
        while (!ro) begin
            @(negedge clk);
            n++;
            if (n > 64) begin
                check("hready_timeout", {31'd0, ro}, 32'd1);
                break;
            end
        end
        @(negedge clk);
        pend_wd = wd;
    endtask

    task automatic wr(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] tr = 2'b10);
        issue(1'b1, 1'b1, sz, a, d, tr);
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] tr = 2'b10);
        issue(1'b1, 1'b0, 3'd2, a, 32'd0, tr);
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; use3 = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; haddr = 32'd0; hwdata = 32'd0; pend_wd = 32'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_hrdata0", rdata0, 32'd0);
        check("reset_hready0", {31'd0, ro0}, 32'd1);
        check("reset_hresp3", {30'd0, resp3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_hrdata", rdata0, 32'd0);
        check("post_reset_hready", {31'd0, ro0}, 32'd1);
        @(negedge clk);

        // Word write then read, zero wait states
        wr(3'd2, 32'h10, 32'hDEADBEEF); idle();
        rd(32'h10); idle();
        check("word_readback", last_rd, 32'hDEADBEEF);

        // Byte and halfword lane writes
        wr(3'd2, 32'h10, 32'h11223344);
        wr(3'd0, 32'h13, 32'hAA000000); idle();
        rd(32'h10); idle();
        check("byte_lane3", last_rd, 32'hAA223344);
        wr(3'd1, 32'h10, 32'h0000BEEF);
        rd(32'h10); idle();
        check("half_lower", last_rd, 32'hAA22BEEF);

        // Read immediately after write to the same word
        wr(3'd2, 32'h20, 32'h12345678);
        rd(32'h20); idle();
        check("raw_forward", last_rd, 32'h12345678);

        // Misaligned halfword at 0x13 lands on lanes 2..3 (or errors)
        wr(3'd1, 32'h13, 32'hCAFE0000);
        rd(32'h10); idle();
`ifdef AHB_SRAM_ERR_EN
        check("misaligned_half", last_rd, 32'hAA22BEEF);
`else
        check("misaligned_half", last_rd, 32'hCAFEBEEF);
`endif

        // Back-to-back SEQ burst writes then reads
        for (int i = 0; i < 4; i++) wr(3'd2, 32'h100 + 32'(4*i), 32'hA5000000 + 32'(i), (i == 0) ? 2'b10 : 2'b11);
        for (int i = 0; i < 4; i++) rd(32'h100 + 32'(4*i), (i == 0) ? 2'b10 : 2'b11);
        idle();
        check("burst0_last", last_rd, 32'hA5000003);

        // Three wait states
        use3 = 1'b1;
        wr(3'd2, 32'h40, 32'h0BADF00D); idle();
        dp_cycles = 0;
        rd(32'h40); idle();
        check("ws3_single_cycles", 32'(dp_cycles), 32'd4);
        check("ws3_single_data", last_rd, 32'h0BADF00D);
        for (int i = 0; i < 4; i++) wr(3'd2, 32'h50 + 32'(4*i), 32'h5A5A0000 + 32'(i), (i == 0) ? 2'b10 : 2'b11);
        idle();
        dp_cycles = 0;
        for (int i = 0; i < 4; i++) rd(32'h50 + 32'(4*i), (i == 0) ? 2'b10 : 2'b11);
        idle();
        check("ws3_burst_cycles", 32'(dp_cycles), 32'd16);
        check("ws3_burst_last", last_rd, 32'h5A5A0003);

        // Reset during the wait states of a write discards it
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40; hwdata = pend_wd;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(32'h40); idle();
        check("reset_drops_write", last_rd, 32'h0BADF00D);

        // Out-of-range address: error response or alias onto word 0
        use3 = 1'b0;
        wr(3'd2, 32'h0, 32'h01020304);
        wr(3'd2, 32'h1000, 32'hFFFFFFFF); idle();
        rd(32'h0); idle();
`ifdef AHB_SRAM_ERR_EN
        check("range_check", last_rd, 32'h01020304);
`else
        check("range_alias", last_rd, 32'hFFFFFFFF);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
